// File: rtl/mprj_cfg_pkg.sv
// Shared constants, FSM state type and per-pad config field map
// for the mprj_io pad configuration loader.
package mprj_cfg_pkg;

    localparam int NUM_PADS_DEF = 38;
    localparam int CFG_BITS_DEF = 13;
    localparam int CLK_DIV_DEF  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LOAD,
        ST_DONE
    } cfg_state_e;

    localparam int CFG_MGMT_EN = 0;
    localparam int CFG_OEB     = 1;
    localparam int CFG_HOLD    = 2;
    localparam int CFG_INP_DIS = 3;
    localparam int CFG_IB_SEL  = 4;
    localparam int CFG_ANA_EN  = 5;
    localparam int CFG_ANA_SEL = 6;
    localparam int CFG_ANA_POL = 7;
    localparam int CFG_SLOW    = 8;
    localparam int CFG_VTRIP   = 9;
    localparam int CFG_DM_LSB  = 10;
    localparam int CFG_DM_MSB  = 12;

    // dm=001, oeb=1, mgmt_en=1: pad owned by management, output off
    localparam logic [CFG_BITS_DEF-1:0] CFG_RESET_DEF = 13'h0403;

endpackage

// File: rtl/mprj_cfg_shift_timer.sv
// Serial-clock half-period divider and remaining-bit counter
// feeding tick and last-bit flags to the loader FSM.
module mprj_cfg_shift_timer #(
    parameter int CLK_DIV  = 2,
    parameter int NUM_BITS = 494
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic load_bits,
    input  logic dec_bits,
    output logic half_tick,
    output logic last_bit
);

    localparam int BW = $clog2(NUM_BITS);
    localparam logic [3:0]    DIV_LAST  = 4'(CLK_DIV - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(NUM_BITS - 1);

    logic [3:0]    div_cnt;
    logic [BW-1:0] bit_cnt;

    assign half_tick = run && (div_cnt == DIV_LAST);
    assign last_bit  = (bit_cnt == '0);

    // Divider restarts whenever the FSM changes state or is idle
    always_ff @(posedge clock) begin
        if (reset || !run || half_tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 4'd1;
    end

    // Counts bits still to shift after the current one
    always_ff @(posedge clock) begin
        if (reset)
            bit_cnt <= '0;
        else if (load_bits)
            bit_cnt <= BITS_LAST;
        else if (dec_bits)
            bit_cnt <= bit_cnt - BW'(1);
    end

endmodule

// File: rtl/mprj_io_cfg_loader.sv
// Per-pad configuration store and serial loader driving the
// mprj_io configuration daisy chain.
module mprj_io_cfg_loader
    import mprj_cfg_pkg::*;
#(
    parameter int NUM_PADS = NUM_PADS_DEF,
    parameter int CFG_BITS = CFG_BITS_DEF,
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter logic [CFG_BITS-1:0] CFG_RESET = CFG_RESET_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_wr_en,
    input  logic [5:0]          cfg_wr_idx,
    input  logic [CFG_BITS-1:0] cfg_wr_data,
    input  logic [5:0]          cfg_rd_idx,
    output logic [CFG_BITS-1:0] cfg_rd_data,
    input  logic                xfer_start,
    output logic                busy,
    output logic                done,
    output logic                wr_reject,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load,
    output logic                serial_resetn
);

    localparam int PW  = $clog2(NUM_PADS);
    localparam int BIW = $clog2(CFG_BITS);
    localparam logic [PW-1:0]  PAD_LAST = PW'(NUM_PADS - 1);
    localparam logic [BIW-1:0] BIT_LAST = BIW'(CFG_BITS - 1);

    logic [CFG_BITS-1:0] cfg_mem [NUM_PADS];
    cfg_state_e          state;
    logic [PW-1:0]       pad_ptr;
    logic [BIW-1:0]      bit_ptr;
    logic [PW-1:0]       next_pad;
    logic [BIW-1:0]      next_bit;
    logic                first_bit;
    logic                half_tick;
    logic                last_bit;

    mprj_cfg_shift_timer #(
        .CLK_DIV  (CLK_DIV),
        .NUM_BITS (NUM_PADS * CFG_BITS)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .run       (busy),
        .load_bits (state == ST_IDLE && xfer_start),
        .dec_bits  (state == ST_SHIFT_HI && half_tick && !last_bit),
        .half_tick (half_tick),
        .last_bit  (last_bit)
    );

    assign cfg_rd_data = (!reset && int'(cfg_rd_idx) < NUM_PADS)
                       ? cfg_mem[cfg_rd_idx] : '0;

    // A write landing with xfer_start must be seen by the first bit
    assign first_bit = (cfg_wr_en && int'(cfg_wr_idx) == NUM_PADS - 1)
                     ? cfg_wr_data[CFG_BITS-1]
                     : cfg_mem[PAD_LAST][CFG_BITS-1];

    // Step MSB-first within a word, then move to the next lower pad
    always_comb begin
        next_pad = pad_ptr;
        next_bit = bit_ptr - BIW'(1);
        if (bit_ptr == '0) begin
            next_pad = pad_ptr - PW'(1);
            next_bit = BIT_LAST;
        end
    end

    // Config array; frozen while a transfer is in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_PADS; i++)
                cfg_mem[i] <= CFG_RESET;
        end else if (cfg_wr_en && !busy &&
                     int'(cfg_wr_idx) < NUM_PADS) begin
            cfg_mem[cfg_wr_idx] <= cfg_wr_data;
        end
    end

    // Transfer sequencer with registered chain outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            wr_reject     <= 1'b0;
            serial_clock  <= 1'b0;
            serial_data   <= 1'b0;
            serial_load   <= 1'b0;
            serial_resetn <= 1'b0;
            pad_ptr       <= '0;
            bit_ptr       <= '0;
        end else begin
            serial_resetn <= 1'b1;
            done          <= 1'b0;
            wr_reject     <= cfg_wr_en && busy;
            unique case (state)
                ST_IDLE: begin
                    if (xfer_start) begin
                        state        <= ST_SHIFT_LO;
                        busy         <= 1'b1;
                        serial_clock <= 1'b0;
                        pad_ptr      <= PAD_LAST;
                        bit_ptr      <= BIT_LAST;
                        serial_data  <= first_bit;
                    end
                end
                ST_SHIFT_LO: begin
                    if (half_tick) begin
                        state        <= ST_SHIFT_HI;
                        serial_clock <= 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (half_tick) begin
                        serial_clock <= 1'b0;
                        if (last_bit) begin
                            state       <= ST_LOAD;
                            serial_load <= 1'b1;
                        end else begin
                            state       <= ST_SHIFT_LO;
                            pad_ptr     <= next_pad;
                            bit_ptr     <= next_bit;
                            serial_data <= cfg_mem[next_pad][next_bit];
                        end
                    end
                end
                ST_LOAD: begin
                    if (half_tick) begin
                        state       <= ST_DONE;
                        serial_load <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mprj_io_cfg_loader.md
Name: mprj_io_cfg_loader

Overview:
- Holds one configuration word per user-project I/O pad, written by the management core.
- On request, serially shifts all words into the per-pad configuration daisy chain that drives the mprj_io pad control inputs (dm, inp_dis, oeb, slow_sel, and the rest).
- Generates the chain's serial clock, data, load strobe and reset, and sequences the whole transfer.
- Sits in the management area between the housekeeping register interface and the chip_io padframe.

Parameters:
- NUM_PADS, 38, number of pads in the chain; equals `MPRJ_IO_PADS.
- CFG_BITS, 13, configuration bits per pad.
- CLK_DIV, 2, core clocks per serial-clock half-period; legal range 1..15.
- CFG_RESET, 13'h0403, reset value of every stored configuration word.

Ports:
- clock  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- cfg_wr_en  input  1  write strobe for the configuration array.
- cfg_wr_idx  input  6  pad index to write; values >= NUM_PADS are ignored.
- cfg_wr_data  input  CFG_BITS  configuration word to write.
- cfg_rd_idx  input  6  pad index to read; combinational read.
- cfg_rd_data  output  CFG_BITS  stored word at cfg_rd_idx; 0 when the index is out of range.
- xfer_start  input  1  one-cycle request to shift the full array into the chain.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse when the load strobe completes.
- wr_reject  output  1  one-cycle pulse when a write arrives while busy.
- serial_clock  output  1  chain shift clock.
- serial_data  output  1  chain serial data.
- serial_load  output  1  chain parallel-load strobe.
- serial_resetn  output  1  chain reset, active low.

Behaviour:
Reset (synchronous, active-high):
- While reset is high: all outputs are 0, including serial_resetn, so the chain is held in reset.
- Every stored word is set to CFG_RESET and the FSM goes to IDLE.
- serial_resetn returns to 1 on the first cycle after reset deasserts.

FSM states: IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE.
- IDLE: when xfer_start=1, go to SHIFT_LO.
  - The bit counter is set to NUM_PADS*CFG_BITS-1.
  - The snapshot pointer is set to pad NUM_PADS-1, bit CFG_BITS-1.
  - busy rises on the next cycle.
- SHIFT_LO: serial_clock=0 and serial_data presents the current bit, held for CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI: serial_clock=1 for CLK_DIV cycles; serial_data stays stable.
  - If the bit counter is 0, go to LOAD.
  - Otherwise decrement the counter, advance the pointer and go to SHIFT_LO.
- LOAD: serial_clock=0 and serial_load=1 for CLK_DIV cycles, then go to DONE.
- DONE: done=1 for one cycle, busy=0 in that cycle, then go to IDLE.

Shift order:
- Highest-indexed pad first, MSB first within each word.
- After the transfer, pad 0's word sits nearest the chain head.

Timing:
- One transfer is NUM_PADS*CFG_BITS*2*CLK_DIV + CLK_DIV busy cycles: 1978 at the defaults.
- done follows the last busy cycle.

Counters:
- Bit counter width is clog2(NUM_PADS*CFG_BITS).
- Divider counter is 4 bits and reloads on every state change.
- Pointer wrap: bit index goes 0 → CFG_BITS-1 and the pad index decrements at the same time. There is no wrap past pad 0; the counter terminates first.

Boundary and conflict rules:
- xfer_start while busy or in DONE: ignored, with no queueing.
- cfg_wr_en while busy: the write is dropped and wr_reject pulses. This guarantees a consistent image.
- cfg_wr_en in IDLE together with xfer_start: the write takes effect first, and the transfer uses the new word.
- reset mid-transfer: immediate abort.
  - serial_load is never asserted and done never fires.
  - serial_resetn=0 clears the chain.
- serial_clock, serial_data and serial_load are registered outputs, so they are glitch-free.

Decomposition:
- Shared package mprj_cfg_pkg:
  - constants NUM_PADS_DEF and CFG_BITS_DEF;
  - the FSM state enum;
  - config-field bit positions: MGMT_EN, OEB, HOLD, INP_DIS, IB_SEL, ANA_EN, ANA_SEL, ANA_POL, SLOW, VTRIP, DM[2:0];
  - the CFG_RESET default.
- One natural sub-module, mprj_cfg_shift_timer: the CLK_DIV divider and bit counter, which issue half-period tick and last-bit flags to the main FSM.

Test Plan:
- Reset release: all 38 words read back as 13'h0403; serial_resetn=0 during reset and 1 one cycle after.
- Write pad 37=13'h1FFF and pad 0=13'h0001, then xfer_start:
  - the first 13 serial_data samples at serial_clock rising edges are all 1;
  - the last 13 samples are twelve 0s then a 1;
  - serial_load is high for 2 cycles;
  - done arrives exactly 1978 cycles after busy rises.
- Write during busy (idx 5, 13'h0AAA): wr_reject pulses; after done, cfg_rd_data at idx 5 is still 13'h0403.
- xfer_start reissued mid-transfer: no restart; the rising-edge count is exactly 494 and there is a single done pulse.
- Reset asserted at bit 200: serial_load never rises, done stays 0, FSM is in IDLE, and a new xfer_start completes a full 494-bit transfer.
- Write to idx 40 and CLK_DIV=1 build: write ignored and cfg_rd_data=0 for idx 40; transfer length is 989 busy cycles.
